// File: rtl/adc_sample_scheduler.sv
// Periodic two-channel ADC sampler: ticks every SAMPLE_INTERVAL cycles and writes EMG, ECG and
// a status word into RAM ring buffers; the CPU wins address collisions. Option: ADC_SCHED_HALF_IRQ_EN.
module adc_sample_scheduler #(
  parameter int unsigned SAMPLE_INTERVAL = 175000,
  parameter int unsigned CNT_WIDTH       = 18,
  parameter logic [11:0] EMG_BASE        = 12'hC00,
  parameter logic [11:0] ECG_BASE        = 12'h800,
  parameter int unsigned DEPTH_LOG2      = 6,
  parameter logic [11:0] STATUS_ADDR     = 12'hFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] emg_data,
  input  logic [31:0] ecg_data,
  input  logic        cpu_wEn,
  input  logic [11:0] cpu_addr,
  output logic        adc_wEn,
  output logic [11:0] adc_addr,
  output logic [31:0] adc_dataIn,
  output logic        busy,
  output logic        overrun,
  output logic        buf_irq,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_WR_EMG, S_WR_ECG, S_WR_STAT} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [31:0]           r_emg;
  logic [31:0]           r_ecg;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [15:0]           r_seq;
  logic [7:0]            r_ovr_cnt;
  logic                  r_overrun;

  logic                  w_tick;
  logic                  w_write;
  logic                  w_wen;
  logic [11:0]           w_addr;
  logic [31:0]           w_data;
  logic [DEPTH_LOG2-1:0] w_wr_ptr_next;
  logic [11:0]           w_ptr12;

  assign w_tick        = enable && (r_cnt == CNT_WIDTH'(SAMPLE_INTERVAL - 1));
  assign w_wr_ptr_next = r_wr_ptr + DEPTH_LOG2'(1);
  assign w_ptr12       = 12'(r_wr_ptr);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Write address/data per state; the CPU owns the port whenever it targets the same word.
  always_comb begin
    w_write = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    case (r_state)
      S_WR_EMG: begin
        w_write = 1'b1;
        w_addr  = EMG_BASE + w_ptr12;
        w_data  = r_emg;
      end
      S_WR_ECG: begin
        w_write = 1'b1;
        w_addr  = ECG_BASE + w_ptr12;
        w_data  = r_ecg;
      end
      S_WR_STAT: begin
        w_write = 1'b1;
        w_addr  = STATUS_ADDR;
        w_data  = {r_seq, r_ovr_cnt, 8'(r_wr_ptr)};
      end
      default: ;
    endcase
    w_wen = w_write && !(cpu_wEn && (cpu_addr == w_addr));
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_tick) w_state_next = S_WR_EMG;
      S_WR_EMG:  if (w_wen)  w_state_next = S_WR_ECG;
      S_WR_ECG:  if (w_wen)  w_state_next = S_WR_STAT;
      S_WR_STAT: if (w_wen)  w_state_next = S_IDLE;
      default:               w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_emg     <= '0;
      r_ecg     <= '0;
      r_wr_ptr  <= '0;
      r_seq     <= '0;
      r_ovr_cnt <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (!enable || w_tick) r_cnt <= '0;
      else                   r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (w_tick && (r_state == S_IDLE)) begin
        r_emg <= emg_data;
        r_ecg <= ecg_data;
      end
      // A tick arriving mid-sequence is lost; the count saturates so software sees "many".
      if (w_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
        if (r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
      end
      if ((r_state == S_WR_ECG) && w_wen)  r_wr_ptr <= w_wr_ptr_next;
      if ((r_state == S_WR_STAT) && w_wen) r_seq    <= r_seq + 16'd1;
    end
  end

  assign adc_wEn    = w_wen;
  assign adc_addr   = w_addr;
  assign adc_dataIn = w_data;
  assign busy       = (r_state != S_IDLE);
  assign overrun    = r_overrun;
  assign dbg_state  = r_state;

`ifdef ADC_SCHED_HALF_IRQ_EN
  localparam logic [DEPTH_LOG2-1:0] HALF = DEPTH_LOG2'(1) << (DEPTH_LOG2 - 1);
  assign buf_irq = (r_state == S_WR_ECG) && w_wen &&
                   ((w_wr_ptr_next == '0) || (w_wr_ptr_next == HALF));
`else
  assign buf_irq = 1'b0;
`endif

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: directed walk-through of the sample sequence, then randomized
// enable/CPU/reset traffic checked against a transaction-level expected-write queue.
module tb_adc_sample_scheduler;

  localparam int SI    = 8;
  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;
`ifdef ADC_SCHED_HALF_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] emg_data = '0;
  logic [31:0] ecg_data = '0;
  logic        cpu_wEn = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic        adc_wEn;
  logic [11:0] adc_addr;
  logic [31:0] adc_dataIn;
  logic        busy;
  logic        overrun;
  logic        buf_irq;
  logic [1:0]  dbg_state;

  adc_sample_scheduler #(
    .SAMPLE_INTERVAL(SI), .CNT_WIDTH(4), .EMG_BASE(12'hC00), .ECG_BASE(12'h800),
    .DEPTH_LOG2(DL), .STATUS_ADDR(12'hFFF)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .emg_data(emg_data), .ecg_data(ecg_data),
    .cpu_wEn(cpu_wEn), .cpu_addr(cpu_addr), .adc_wEn(adc_wEn), .adc_addr(adc_addr),
    .adc_dataIn(adc_dataIn), .busy(busy), .overrun(overrun), .buf_irq(buf_irq),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: each entry is {irq, is_stat, addr[11:0], data[31:0]} for one expected RAM write.
  logic [45:0] exp_q[$];
  int          m_cnt     = 0;
  int          m_samples = 0;
  int          m_ovr     = 0;
  bit          m_overrun = 1'b0;

  function automatic logic [45:0] mk(bit irq, bit st, logic [11:0] a, logic [31:0] d);
    return {irq, st, a, d};
  endfunction

  // Compare this cycle's outputs against the queue head, then advance the model by one edge
  // using the inputs that the coming edge will sample.
  task automatic sample();
    logic [45:0] e;
    logic [31:0] exp_data;
    bit          pend;
    bit          exp_irq;
    bit          tick;
    int          ptr;
    int          nxt;
    #1;
    pend    = (exp_q.size() != 0);
    exp_irq = 1'b0;
    check_eq("busy", busy, pend);
    check_eq("overrun", overrun, m_overrun);
    if (pend) begin
      e        = exp_q[0];
      exp_data = e[44] ? (e[31:0] | (32'(m_ovr) << 8)) : e[31:0];
      check_eq("addr", adc_addr, e[43:32]);
      check_eq("data", adc_dataIn, exp_data);
      check_eq("wen", adc_wEn, !(cpu_wEn && (cpu_addr == e[43:32])));
      exp_irq = e[45] && adc_wEn;
      if (adc_wEn && !reset) void'(exp_q.pop_front());
    end else begin
      check_eq("idle_wen", adc_wEn, 0);
      check_eq("idle_addr", adc_addr, 0);
      check_eq("idle_data", adc_dataIn, 0);
    end
    check_eq("buf_irq", buf_irq, exp_irq);

    if (reset) begin
      exp_q.delete();
      m_cnt = 0; m_samples = 0; m_ovr = 0; m_overrun = 1'b0;
    end else begin
      tick = enable && (m_cnt == SI - 1);
      m_cnt = (enable && !tick) ? m_cnt + 1 : 0;
      if (tick && pend) begin
        m_overrun = 1'b1;
        if (m_ovr < 255) m_ovr++;
      end else if (tick) begin
        ptr = m_samples % DEPTH;
        nxt = (m_samples + 1) % DEPTH;
        exp_q.push_back(mk(1'b0, 1'b0, 12'hC00 + 12'(ptr), emg_data));
        exp_q.push_back(mk(IRQ_EN && (nxt == 0 || nxt == DEPTH / 2), 1'b0,
                           12'h800 + 12'(ptr), ecg_data));
        exp_q.push_back(mk(1'b0, 1'b1, 12'hFFF, {16'(m_samples), 8'h00, 8'(nxt)}));
        m_samples++;
      end
    end
  endtask

  task automatic advance();
    @(negedge clock);
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  int burst_left = 0;

  task automatic pick_cpu_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 4)       cpu_addr = 12'hC00 + 12'(k);
    else if (k < 8)  cpu_addr = 12'h800 + 12'(k - 4);
    else if (k == 8) cpu_addr = 12'hFFF;
    else             cpu_addr = 12'($urandom);
  endtask

  initial begin
    @(negedge clock);
    reset = 1'b1; enable = 1'b1;
    emg_data = 32'hAAAA0001; ecg_data = 32'hBBBB0002;
    repeat (3) cycle();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", dbg_state, 0);

    // First sample: tick in cycle 7, writes in cycles 8..10.
    reset = 1'b0;
    repeat (8) cycle();
    sample(); check_eq("s1_emg_addr", adc_addr, 12'hC00); check_eq("s1_emg_wen", adc_wEn, 1); advance();
    sample(); check_eq("s1_ecg_data", adc_dataIn, 32'hBBBB0002); advance();
    sample(); check_eq("s1_stat", adc_dataIn, 32'h0000_0001); advance();
    sample(); check_eq("s1_done", busy, 0); advance();
    repeat (5) cycle();

    // CPU holds the second sample's ECG slot for two cycles.
    cpu_wEn = 1'b1; cpu_addr = 12'h801;
    sample(); check_eq("col_wen0", adc_wEn, 0); advance();
    sample(); check_eq("col_wen1", adc_wEn, 0); advance();
    cpu_wEn = 1'b0;
    sample(); check_eq("col_late_wen", adc_wEn, 1); check_eq("col_late_data", adc_dataIn, 32'hBBBB0002); advance();
    cycle();

    // Long stall on the status word forces the next tick to be dropped.
    cpu_wEn = 1'b1; cpu_addr = 12'hFFF;
    repeat (12) cycle();
    cpu_wEn = 1'b0;
    sample(); check_eq("ovr_flag", overrun, 1); check_eq("ovr_stat", adc_dataIn, 32'h0002_0103); advance();
    repeat (7) cycle();

    // Reset lands during WR_ECG of the fourth sample.
    reset = 1'b1;
    sample(); check_eq("rst_mid_addr", adc_addr, 12'h803); advance();
    reset = 1'b0;
    sample(); check_eq("rst_mid_busy", busy, 0); check_eq("rst_mid_ovr", overrun, 0); check_eq("rst_mid_wen", adc_wEn, 0); advance();
    repeat (7) cycle();
    sample(); check_eq("rst_restart_addr", adc_addr, 12'hC00); advance();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(0, 19) != 0);
      emg_data = $urandom;
      ecg_data = $urandom;
      reset    = ($urandom_range(0, 499) == 0);
      if (burst_left > 0) begin
        burst_left--;
        cpu_wEn = 1'b1;
      end else if ($urandom_range(0, 99) < 3) begin
        burst_left = $urandom_range(6, 14);
        cpu_wEn = 1'b1;
        pick_cpu_addr();
      end else begin
        cpu_wEn = ($urandom_range(0, 99) < 40);
        pick_cpu_addr();
      end
      cycle();
    end

    reset = 1'b0; enable = 1'b0; cpu_wEn = 1'b0;
    repeat (30) cycle();
    check_eq("drain", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sample_scheduler.md
Name: adc_sample_scheduler

Overview:
- Sequences periodic EMG/ECG sample capture into the RAM ADC write port.
- Generates the sample tick and snapshots both ADC channels on the same cycle.
- Writes the two samples into per-channel ring buffers in RAM, then writes a status word.
- Arbitrates against CPU data-memory writes and sits between adc_data_capture and RAM inside Wrapper.

Parameters:
- SAMPLE_INTERVAL, 175000, clock cycles between sample ticks (5 ms at 35 MHz); must be at least 5.
- CNT_WIDTH, 18, width of the interval counter; must satisfy 2^CNT_WIDTH > SAMPLE_INTERVAL.
- EMG_BASE, 12'hC00, RAM word address of EMG ring buffer entry 0.
- ECG_BASE, 12'h800, RAM word address of ECG ring buffer entry 0.
- DEPTH_LOG2, 6, log2 of ring depth in words per channel; legal range 1..8.
- STATUS_ADDR, 12'hFFF, RAM word address of the status word.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  tick generation enable.
- emg_data  in  32  EMG sample from adc_data_capture.
- ecg_data  in  32  ECG sample from adc_data_capture.
- cpu_wEn  in  1  CPU RAM write enable (mwe).
- cpu_addr  in  12  CPU RAM address (memAddr[11:0]).
- adc_wEn  out  1  RAM ADC port write enable.
- adc_addr  out  12  RAM ADC port address.
- adc_dataIn  out  32  RAM ADC port write data.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky flag: a tick was dropped.
- buf_irq  out  1  buffer interrupt pulse; see Optional Feature.

Behaviour:
- Reset, synchronous: counter=0, state=IDLE, wr_ptr=0, seq=0, overrun_cnt=0, sample latches=0. All outputs are 0.
- Interval counter:
  - Increments each cycle while enable=1. While enable=0 it holds at 0.
  - A tick occurs in any cycle where counter==SAMPLE_INTERVAL-1; the counter returns to 0 on the next edge.
  - Dropping enable does not abort a sequence already in progress.
- Tick in IDLE: emg_data and ecg_data are latched at that edge and state moves to WR_EMG.
- Tick while not IDLE: the tick is dropped, overrun is set (sticky until reset), and overrun_cnt increments, saturating at 255.
- States: IDLE -> WR_EMG -> WR_ECG -> WR_STAT -> IDLE.
  - WR_EMG: adc_addr = EMG_BASE + wr_ptr (12-bit add, wraps); data = latched EMG sample.
  - WR_ECG: adc_addr = ECG_BASE + wr_ptr; data = latched ECG sample.
  - WR_STAT: adc_addr = STATUS_ADDR; data = {seq[15:0], overrun_cnt[7:0], wr_ptr_next zero-extended to 8 bits}.
- Outputs are combinational from state and registers. adc_wEn=1 in each write state unless a collision occurs.
- Collision: cpu_wEn=1 and cpu_addr==adc_addr. Then adc_wEn=0 and the state holds; the write retries next cycle. The CPU always wins, with unbounded stall.
- Write latency: the first write (WR_EMG) is asserted the cycle after the tick. With no collisions the three writes take 3 consecutive cycles and busy stays high for 3 cycles.
- On WR_ECG completion: wr_ptr increments modulo 2^DEPTH_LOG2, so 63 -> 0 for the default depth.
- On WR_STAT completion: seq increments modulo 2^16.
- Reset asserted mid-sequence: return to reset values on the next edge; the pending writes are abandoned.
- adc_dataIn = 0 in IDLE.

Optional Feature:
- Macro: ADC_SCHED_HALF_IRQ_EN.
- Defined: buf_irq is a one-cycle pulse, coincident with the WR_ECG write completing, whenever wr_ptr_next == 0 or wr_ptr_next == 2^(DEPTH_LOG2-1). This lets software drain the half of the ring just filled.
- Undefined: buf_irq is tied to 0, and the port stays present so the interface is identical either way.

Test Plan (all scenarios use SAMPLE_INTERVAL=8, DEPTH_LOG2=2):
- Reset release, enable=1, emg=32'hAAAA0001, ecg=32'hBBBB0002. Expected:
  - Tick at cycle 7 after release.
  - Writes on cycles 8/9/10: C00<-AAAA0001, 800<-BBBB0002, FFF<-32'h0000_0001.
  - busy high for exactly 3 cycles.
- Five ticks. Expected:
  - EMG addresses written are C00, C01, C02, C03, C00 (wrap).
  - The 4th status word has low byte 0 and seq[31:16]=3.
- cpu_wEn=1 with cpu_addr=12'h801 held for 2 cycles during the second sample's WR_ECG. Expected:
  - adc_wEn low for those 2 cycles.
  - ECG write lands 2 cycles late with the correct data.
  - Next tick unaffected.
- Hold a collision for 10 cycles. Expected:
  - The next tick is dropped; overrun=1.
  - The following status word has bits[15:8]=8'h01.
  - overrun stays 1 until reset.
- Assert reset during WR_ECG. Expected:
  - No further adc_wEn; all outputs 0.
  - wr_ptr=0; the next sample writes C00.
- With ADC_SCHED_HALF_IRQ_EN defined: buf_irq pulses on the 2nd and 4th sample's WR_ECG, otherwise 0. With the macro undefined, buf_irq stays 0 throughout.
